// File: rtl/pcie_icm_rx_stream_buf.sv
// Receive-stream elastic buffer: show-ahead FIFO with READY_LAT skid room,
// packet counting, optional store-and-forward gating and sticky error flags.
module pcie_icm_rx_stream_buf #(
   parameter int DATA_W    = 82,
   parameter int DEPTH     = 16,
   parameter int READY_LAT = 3,
   parameter int STORE_FWD = 0
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_sop,
   input  logic                     in_eop,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_sop,
   output logic                     out_eop,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [$clog2(DEPTH):0]   pkt_cnt,
   output logic                     ovf_err,
   output logic                     frm_err,
   input  logic                     clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = DATA_W + 2;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] RLAT_L  = LW'(READY_LAT);

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [LW-1:0] level_q, level_d;
   logic [LW-1:0] pkt_q, pkt_d;
   logic          in_pkt_q, in_pkt_d;
   logic          ovf_q, ovf_d;
   logic          frm_q, frm_d;
   logic          rdy_q, rdy_d;

   logic [EW-1:0] head;
   logic          full, vld, push, pop, drop, frm_ev;
   logic          add_pkt, sub_pkt;

   assign head = mem_q[rd_q];
   assign full = (level_q == DEPTH_L);

   // Store-and-forward also releases a full buffer so an oversized packet cannot deadlock
   assign vld = (STORE_FWD != 0) ? ((pkt_q != '0) || full)
                                 : (level_q != '0);

   assign pop     = vld && out_ready;
   assign push    = in_valid && (!full || pop);
   assign drop    = in_valid && full && !pop;
   assign frm_ev  = push && (in_sop == in_pkt_q);
   assign add_pkt = push && in_eop;
   assign sub_pkt = pop && head[EW-2];

   always_comb begin
      level_d = level_q;
      if (push && !pop) level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);

      pkt_d = pkt_q;
      if (add_pkt && !sub_pkt) pkt_d = pkt_q + LW'(1);
      else if (sub_pkt && !add_pkt) pkt_d = pkt_q - LW'(1);

      in_pkt_d = in_pkt_q;
      if (push) begin
         if (in_eop) in_pkt_d = 1'b0;
         else if (in_sop) in_pkt_d = 1'b1;
      end

      ovf_d = drop || (ovf_q && !clr_err);
      frm_d = frm_ev || (frm_q && !clr_err);
      rdy_d = (DEPTH_L - level_d) > RLAT_L;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_q     <= '0;
         rd_q     <= '0;
         level_q  <= '0;
         pkt_q    <= '0;
         in_pkt_q <= 1'b0;
         ovf_q    <= 1'b0;
         frm_q    <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         wr_q     <= wr_q + AW'(push);
         rd_q     <= rd_q + AW'(pop);
         level_q  <= level_d;
         pkt_q    <= pkt_d;
         in_pkt_q <= in_pkt_d;
         ovf_q    <= ovf_d;
         frm_q    <= frm_d;
         rdy_q    <= rdy_d;
      end
   end

   // Storage is not reset; at full the slot being popped is the one overwritten
   always_ff @(posedge clk) begin
      if (push && !srst) mem_q[wr_q] <= {in_sop, in_eop, in_data};
   end

   assign in_ready  = rdy_q;
   assign out_valid = vld;
   assign out_data  = head[DATA_W-1:0];
   assign out_sop   = vld && head[EW-1];
   assign out_eop   = vld && head[EW-2];
   assign level     = level_q;
   assign pkt_cnt   = pkt_q;
   assign ovf_err   = ovf_q;
   assign frm_err   = frm_q;

endmodule

// File: tb/tb_pcie_icm_rx_stream_buf.sv
// Bench for pcie_icm_rx_stream_buf: cut-through instance with a beat
// scoreboard, plus a store-and-forward instance on the same inputs.
module tb_pcie_icm_rx_stream_buf;

   localparam int DW = 82;

   logic clk = 1'b0;
   logic srst = 1'b1;
   logic iv = 1'b0, isop = 1'b0, ieop = 1'b0, ordy = 1'b0, clr = 1'b0;
   logic [DW-1:0] id = '0;

   logic ir0, ov0, os0, oe0, ovf0, frm0;
   logic ir1, ov1, os1, oe1, ovf1, frm1;
   logic [DW-1:0] od0, od1;
   logic [4:0] lv0, pc0, lv1, pc1;

   int checks = 0;
   int failures = 0;
   int mlvl = 0;
   logic [DW+1:0] sb[$];

   typedef struct {
      logic v, s, e, r, c;
      logic [4:0] lvl;
      logic rdy, ovf;
   } vec_t;
   vec_t tbl[18];

   always #5 clk = ~clk;

   pcie_icm_rx_stream_buf #(.STORE_FWD(0)) u_ct (
      .clk(clk), .srst(srst), .in_valid(iv), .in_data(id),
      .in_sop(isop), .in_eop(ieop), .in_ready(ir0),
      .out_valid(ov0), .out_data(od0), .out_sop(os0), .out_eop(oe0),
      .out_ready(ordy), .level(lv0), .pkt_cnt(pc0),
      .ovf_err(ovf0), .frm_err(frm0), .clr_err(clr)
   );

   pcie_icm_rx_stream_buf #(.STORE_FWD(1)) u_sf (
      .clk(clk), .srst(srst), .in_valid(iv), .in_data(id),
      .in_sop(isop), .in_eop(ieop), .in_ready(ir1),
      .out_valid(ov1), .out_data(od1), .out_sop(os1), .out_eop(oe1),
      .out_ready(ordy), .level(lv1), .pkt_cnt(pc1),
      .ovf_err(ovf1), .frm_err(frm1), .clr_err(clr)
   );

   task automatic chk(input string nm, input logic [95:0] act,
                      input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic s, input logic e,
                       input logic [DW-1:0] d, input logic r,
                       input logic c);
      logic pop, push;
      logic [DW+1:0] exp;
      iv = v; isop = s; ieop = e; id = d; ordy = r; clr = c;
      #1;
      pop = (mlvl != 0) && r;
      if (pop) begin
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_underflow actual=empty required=beat");
         end else begin
            exp = sb.pop_front();
            chk("beat", {os0, oe0, od0}, exp);
         end
      end
      push = v && ((mlvl < 16) || pop);
      if (push) sb.push_back({s, e, d});
      mlvl = mlvl + int'(push) - int'(pop);
      @(posedge clk);
      #1;
      chk("lvl0", lv0, 96'(mlvl));
      chk("vld0", ov0, mlvl != 0);
   endtask

   task automatic idle(input logic r);
      step(1'b0, 1'b0, 1'b0, '0, r, 1'b0);
   endtask

   task automatic do_rst(input logic v, input logic r, input logic c);
      srst = 1'b1; iv = v; isop = 1'b0; ieop = 1'b0; ordy = r; clr = c;
      @(posedge clk);
      #1;
      srst = 1'b0; iv = 1'b0; ordy = 1'b0; clr = 1'b0;
      mlvl = 0;
      sb.delete();
   endtask

   initial begin
      for (int i = 0; i < 17; i++) begin
         tbl[i].v = 1'b1; tbl[i].s = (i == 0); tbl[i].e = 1'b0;
         tbl[i].r = 1'b0; tbl[i].c = 1'b0;
         tbl[i].lvl = 5'((i < 16) ? i + 1 : 16);
         tbl[i].rdy = (i < 12);
         tbl[i].ovf = (i == 16);
      end
      tbl[17] = '{v: 1'b0, s: 1'b0, e: 1'b0, r: 1'b0, c: 1'b1,
                  lvl: 5'd16, rdy: 1'b0, ovf: 1'b0};

      repeat (2) @(posedge clk);
      #1;
      do_rst(1'b0, 1'b0, 1'b0);
      chk("rst_lvl", lv0, 0);
      chk("rst_pkt", pc0, 0);
      chk("rst_vld", ov0, 0);
      chk("rst_rdy", ir0, 1);
      chk("rst_sop", {os0, oe0}, 0);
      chk("rst_err", {ovf0, frm0, ovf1, frm1}, 0);

      // one 4-beat packet, out_ready high
      step(1'b1, 1'b1, 1'b0, 82'h11, 1'b1, 1'b0);
      chk("p4_vld_after_b0", ov0, 1);
      chk("p4_sop", os0, 1);
      step(1'b1, 1'b0, 1'b0, 82'h22, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 82'h33, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 82'h44, 1'b1, 1'b0);
      chk("p4_pkt_peak", pc0, 1);
      chk("p4_eop", oe0, 1);
      idle(1'b1);
      chk("p4_pkt_end", pc0, 0);
      chk("p4_frm", frm0, 0);

      // fill with out_ready low, overflow, then clr_err
      do_rst(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 18; i++) begin
         step(tbl[i].v, tbl[i].s, tbl[i].e, 82'(i + 4096),
              tbl[i].r, tbl[i].c);
         chk($sformatf("tbl%0d_rdy", i), ir0, tbl[i].rdy);
         chk($sformatf("tbl%0d_ovf", i), ovf0, tbl[i].ovf);
         chk($sformatf("tbl%0d_lvl", i), lv0, tbl[i].lvl);
      end

      // push and pop together while full
      step(1'b1, 1'b0, 1'b1, 82'h5eed, 1'b1, 1'b0);
      chk("full_pp_lvl", lv0, 16);
      chk("full_pp_ovf", ovf0, 0);
      chk("full_pp_pkt", pc0, 1);
      for (int i = 0; i < 16; i++) idle(1'b1);
      chk("drain_sb", sb.size(), 0);
      chk("drain_pkt", pc0, 0);

      // back-to-back sop beats, clr racing an error
      do_rst(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 82'hA1, 1'b1, 1'b0);
      chk("frm_first", frm0, 0);
      step(1'b1, 1'b1, 1'b1, 82'hA2, 1'b1, 1'b0);
      chk("frm_second", frm0, 1);
      step(1'b1, 1'b0, 1'b0, 82'hA3, 1'b1, 1'b1);
      chk("frm_clr_race", frm0, 1);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
      chk("frm_clr", frm0, 0);
      idle(1'b1);
      chk("frm_sb", sb.size(), 0);

      // reset with 7 beats and 2 packets buffered
      do_rst(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 82'h1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 82'h2, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 82'h3, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b0, 1'b0, 82'(i + 4), 1'b0, 1'b0);
      chk("pre_rst_lvl", lv0, 7);
      chk("pre_rst_pkt", pc0, 2);
      do_rst(1'b1, 1'b1, 1'b1);
      chk("mid_rst_lvl", lv0, 0);
      chk("mid_rst_pkt", pc0, 0);
      chk("mid_rst_vld", ov0, 0);
      chk("mid_rst_rdy", ir0, 1);
      step(1'b1, 1'b0, 1'b0, 82'h9, 1'b0, 1'b0);
      chk("post_rst_frm", frm0, 1);

      // store-and-forward: eop delayed by 5 idle cycles
      do_rst(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 82'hC1, 1'b1, 1'b0);
      chk("sf_b0_vld", ov1, 0);
      step(1'b1, 1'b0, 1'b0, 82'hC2, 1'b1, 1'b0);
      chk("sf_b1_vld", ov1, 0);
      for (int i = 0; i < 5; i++) begin
         idle(1'b1);
         chk($sformatf("sf_gap%0d_vld", i), ov1, 0);
      end
      step(1'b1, 1'b0, 1'b1, 82'hC3, 1'b1, 1'b0);
      chk("sf_eop_vld", ov1, 1);
      chk("sf_eop_pkt", pc1, 1);
      chk("sf_h0", {os1, oe1, od1}, {2'b10, 82'hC1});
      idle(1'b1);
      chk("sf_h1", {os1, oe1, od1}, {2'b00, 82'hC2});
      idle(1'b1);
      chk("sf_h2", {os1, oe1, od1}, {2'b01, 82'hC3});
      idle(1'b1);
      chk("sf_done", {ov1, lv1, pc1}, 0);

      // store-and-forward: oversized packet released at full
      do_rst(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, i == 0, 1'b0, 82'(i + 256), 1'b0, 1'b0);
         chk($sformatf("sf_big%0d_vld", i), ov1, i == 15);
      end
      chk("sf_big_lvl", lv1, 16);
      chk("sf_big_pkt", pc1, 0);
      do_rst(1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
